dmem_arbiter: RTL and testbench

Shares the processor's single byte-wide, 32-entry data memory between two word-level requesters: port 0 (CPU datapath load/store) and port 1 (loader/debug engine). Each accepted request is serialized into four big-endian byte beats on the memory port, with writes split into bytes and reads reassembled into a 32-bit word. The block sits between the datapath's load/store path and the `datmem` byte array, replacing the direct four-byte parallel access.

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_rr_arbiter.sv | 37 +++
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the word-to-byte data memory arbiter.
// Holds the FSM state encoding, beat geometry and the big-endian byte-lane select.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int BEATS  = 4;
    localparam int BYTE_W = 8;
    localparam int BEAT_W = 2;

    // Beat 0 carries the most-significant byte.
    function automatic logic [BYTE_W-1:0] byte_lane(
        input logic [BEATS*BYTE_W-1:0] word,
        input logic [BEAT_W-1:0]       beat
    );
        return word[BYTE_W*(BEATS-1-int'(beat)) +: BYTE_W];
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both word requesters and the byte-wide memory port.
// master = arbiter side, slave = requesters plus memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              req0_done;
    logic [DATA_W-1:0] req0_rdata;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              req1_done;
    logic [DATA_W-1:0] req1_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  mem_rdata,
        output req0_ready, req0_done, req0_rdata,
        output req1_ready, req1_done, req1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output mem_rdata,
        input  req0_ready, req0_done, req0_rdata,
        input  req1_ready, req1_done, req1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_rr_arbiter.sv
// Two-way grant logic: round-robin when DMEM_ARB_RR_EN is defined,
// otherwise fixed priority with port 0 winning contention.
module dmem_rr_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

`ifdef DMEM_ARB_RR_EN
    logic ptr_q;  // 0: port 0 favoured, 1: port 1 favoured
    logic ptr_d;

    always_comb begin
        if (valid_i == 2'b11) grant_o = ptr_q ? 2'b10 : 2'b01;
        else                  grant_o = valid_i;
    end

    // The port just served loses priority at the next contest.
    assign ptr_d = accept_i ? grant_o[0] : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, rst_n, accept_i};

    always_comb begin
        if (valid_i[0]) grant_o = 2'b01;
        else            grant_o = valid_i;
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises word requests from two ports into four big-endian byte beats
// on a shared byte-wide memory. Optional round-robin via DMEM_ARB_RR_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.master bus
);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                owner_q;
    logic [DATA_W-1:0]   asm_q;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;

    logic [1:0]          grant;
    logic                accept;
    logic                last_beat;
    logic [DATA_W-1:0]   asm_next;

    dmem_rr_arbiter u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  ({bus.req1_valid, bus.req0_valid}),
        .accept_i (accept),
        .grant_o  (grant)
    );

    assign accept    = (state_q == ST_IDLE) && (grant != 2'b00);
    assign last_beat = (beat_q == BEAT_W'(BEATS-1));
    assign asm_next  = {asm_q[DATA_W-BYTE_W-1:0], bus.mem_rdata};

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)    state_d = ST_XFER;
            ST_XFER: if (last_beat) state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            owner_q  <= 1'b0;
            asm_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (accept) begin
            beat_q  <= '0;
            owner_q <= grant[1];
            we_q    <= grant[1] ? bus.req1_we    : bus.req0_we;
            addr_q  <= grant[1] ? bus.req1_addr  : bus.req0_addr;
            wdata_q <= grant[1] ? bus.req1_wdata : bus.req0_wdata;
        end else if (state_q == ST_XFER) begin
            beat_q <= beat_q + BEAT_W'(1);
            if (!we_q) begin
                asm_q <= asm_next;
                // The final shift lands straight in the owner's read register.
                if (last_beat && !owner_q) rdata0_q <= asm_next;
                if (last_beat &&  owner_q) rdata1_q <= asm_next;
            end
        end
    end

    always_comb begin
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.req0_done  = 1'b0;
        bus.req1_done  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus.req0_ready = grant[0];
                bus.req1_ready = grant[1];
            end
            ST_XFER: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = addr_q + ADDR_W'(beat_q);
                bus.mem_wdata = byte_lane(wdata_q, beat_q);
            end
            ST_DONE: begin
                bus.req0_done = !owner_q;
                bus.req1_done = owner_q;
            end
            default: ;
        endcase
    end

    assign bus.req0_rdata = rdata0_q;
    assign bus.req1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte memory model and a scoreboard
// of expected beats and completions built from a shadow copy of memory.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;

    typedef struct {
        int         cyc;
        logic [4:0] addr;
        logic [7:0] data;
        logic       we;
    } beat_t;

    typedef struct {
        int          port;
        int          cyc;
        logic        we;
        logic [31:0] rdata;
    } done_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] mem    [DEPTH];
    logic [7:0] shadow [DEPTH];
    beat_t      beat_q [$];
    done_t      done_q [$];
    int         grant_log [$];
    int         grant_cyc [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Byte memory: combinational read, write on the rising edge.
    assign bus.mem_rdata = mem[bus.mem_addr];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hA0 + 8'(i);
        forever begin
            @(posedge clk);
            if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: owns the shadow memory and scoreboard queues.
    initial begin : monitor
        beat_t       b;
        done_t       d;
        int          p;
        logic        we;
        logic [4:0]  a, ak;
        logic [31:0] wd, rd;
        for (int i = 0; i < DEPTH; i++) shadow[i] = 8'hA0 + 8'(i);
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                beat_q.delete();
                done_q.delete();
            end else begin
                if (bus.req0_done || bus.req1_done) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_done", {30'b0, bus.req1_done, bus.req0_done}, 32'd0);
                    end else begin
                        d = done_q.pop_front();
                        check("done_port", {30'b0, bus.req1_done, bus.req0_done}, (d.port == 1) ? 32'd2 : 32'd1);
                        check("done_cycle", cyc, d.cyc);
                        if (!d.we) check("rdata", (d.port == 1) ? bus.req1_rdata : bus.req0_rdata, d.rdata);
                    end
                end
                if (bus.mem_en) begin
                    if (beat_q.size() == 0) begin
                        check("unexpected_beat", {31'b0, bus.mem_en}, 32'd0);
                    end else begin
                        b = beat_q.pop_front();
                        check("beat_cycle", cyc, b.cyc);
                        check("beat_addr", {27'b0, bus.mem_addr}, {27'b0, b.addr});
                        check("beat_we", {31'b0, bus.mem_we}, {31'b0, b.we});
                        if (b.we) check("beat_wdata", {24'b0, bus.mem_wdata}, {24'b0, b.data});
                    end
                end
                if (bus.req0_ready || bus.req1_ready) begin
                    check("ready_onehot", {31'b0, bus.req0_ready && bus.req1_ready}, 32'd0);
                    p  = bus.req1_ready ? 1 : 0;
                    we = p ? bus.req1_we    : bus.req0_we;
                    a  = p ? bus.req1_addr  : bus.req0_addr;
                    wd = p ? bus.req1_wdata : bus.req0_wdata;
                    check("ready_with_valid", {31'b0, p ? bus.req1_valid : bus.req0_valid}, 32'd1);
                    grant_log.push_back(p);
                    grant_cyc.push_back(cyc);
                    rd = '0;
                    for (int k = 0; k < 4; k++) begin
                        ak     = a + 5'(k);
                        b.cyc  = cyc + 1 + k;
                        b.addr = ak;
                        b.we   = we;
                        b.data = 8'(wd >> (24 - 8 * k));
                        beat_q.push_back(b);
                        if (we) shadow[ak] = b.data;
                        rd = (rd << 8) | {24'b0, shadow[ak]};
                    end
                    d.port  = p;
                    d.cyc   = cyc + 5;
                    d.we    = we;
                    d.rdata = rd;
                    done_q.push_back(d);
                end
            end
        end
    end

    task automatic set_port(input int p, input logic v, input logic we,
                            input logic [4:0] a, input logic [31:0] wd);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = wd;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = wd;
        end
    endtask

    task automatic wait_accept(input int p, input int n0);
        bit got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk); #1;
            got = (grant_log.size() > n0);
        end
        check("accept_seen", {31'b0, got}, 32'd1);
        if (got) check("grant_port", grant_log[n0], p);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (beat_q.size() == 0 && done_q.size() == 0) break;
        end
        check("drained", beat_q.size() + done_q.size(), 32'd0);
    endtask

    task automatic request(input int p, input logic we, input logic [4:0] a, input logic [31:0] wd);
        int n0;
        n0 = grant_log.size();
        @(posedge clk); #1;
        set_port(p, 1'b1, we, a, wd);
        wait_accept(p, n0);
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, '0, '0);
        wait_idle();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int n0, n1;
        int exp_p;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en",    {31'b0, bus.mem_en}, 32'd0);
        check("rst_mem_we",    {31'b0, bus.mem_we}, 32'd0);
        check("rst_mem_addr",  {27'b0, bus.mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'b0, bus.mem_wdata}, 32'd0);
        check("rst_ready",     {30'b0, bus.req1_ready, bus.req0_ready}, 32'd0);
        check("rst_done",      {30'b0, bus.req1_done, bus.req0_done}, 32'd0);
        check("rst_rdata0",    bus.req0_rdata, 32'd0);
        check("rst_rdata1",    bus.req1_rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Port 0 word write, then port 1 read-back
        request(0, 1'b1, 5'd4, 32'hDEADBEEF);
        check("mem4", {24'b0, mem[4]}, 32'hDE);
        check("mem5", {24'b0, mem[5]}, 32'hAD);
        check("mem6", {24'b0, mem[6]}, 32'hBE);
        check("mem7", {24'b0, mem[7]}, 32'hEF);
        request(1, 1'b0, 5'd4, 32'h0);
        check("rdata1_held", bus.req1_rdata, 32'hDEADBEEF);
        check("rdata0_untouched", bus.req0_rdata, 32'd0);

        // Address wrap 30,31,0,1
        request(0, 1'b1, 5'd30, 32'h11223344);
        check("mem30", {24'b0, mem[30]}, 32'h11);
        check("mem31", {24'b0, mem[31]}, 32'h22);
        check("mem0",  {24'b0, mem[0]},  32'h33);
        check("mem1",  {24'b0, mem[1]},  32'h44);
        request(1, 1'b0, 5'd30, 32'h0);
        check("rdata1_wrap", bus.req1_rdata, 32'h11223344);

        // Port 1 pulses valid while port 0 owns the bus
        n0 = grant_log.size();
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b1, 5'd12, 32'hCAFEF00D);
        wait_accept(0, n0);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b1, 1'b0, 5'd20, 32'h0);
        @(posedge clk); #1;
        set_port(1, 1'b0, 1'b0, '0, '0);
        wait_idle();
        repeat (3) @(negedge clk);
        check("withdraw_grants", grant_log.size(), n0 + 1);
        check("mem12", {24'b0, mem[12]}, 32'hCA);
        check("mem15", {24'b0, mem[15]}, 32'h0D);

        // Reset during beat 2 of a write to addr 8
        n0 = grant_log.size();
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b1, 5'd8, 32'h55667788);
        wait_accept(0, n0);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_mem_en", {31'b0, bus.mem_en}, 32'd0);
        check("rstmid_mem_we", {31'b0, bus.mem_we}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mem8",  {24'b0, mem[8]},  32'h55);
        check("mem9",  {24'b0, mem[9]},  32'h66);
        check("mem10", {24'b0, mem[10]}, 32'hAA);
        check("mem11", {24'b0, mem[11]}, 32'hAB);
        check("rstmid_rdata1", bus.req1_rdata, 32'd0);
        n0 = grant_log.size();
        @(posedge clk); #1;
        set_port(0, 1'b1, 1'b0, 5'd4, 32'h0);
        #1;
        check("idle_after_reset_ready", {31'b0, bus.req0_ready}, 32'd1);
        wait_accept(0, n0);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, '0, '0);
        wait_idle();

        // Contention from a fresh reset: both ports valid continuously
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n0 = grant_log.size();
        set_port(0, 1'b1, 1'b0, 5'd4, 32'h0);
        set_port(1, 1'b1, 1'b0, 5'd30, 32'h0);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (grant_log.size() >= n0 + 4) break;
        end
        n1 = grant_log.size() - n0;
        check("contention_grants", n1, 32'd4);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        wait_idle();
        for (int i = 0; i < 4 && i < n1; i++) begin
`ifdef DMEM_ARB_RR_EN
            exp_p = i % 2;
`else
            exp_p = 0;
`endif
            check("contention_order", grant_log[n0 + i], exp_p);
            if (i > 0) check("contention_spacing", grant_cyc[n0 + i] - grant_cyc[n0 + i - 1], 32'd6);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
